mips_bus_lsu: RTL and testbench

Load/store initiator for the CPU's memory bus: accepts one byte/half/word load or store from the execute stage, issues the matching read or write on the `address/read/write/waitrequest/byteenable` bus, and returns a right-aligned, optionally sign-extended load result. It sits between the datapath and the bus pins of `mips_cpu_bus`, and is the master end of the interface that the memory models respond to.

---
 rtl/mips_bus_pkg.sv | 41 ++++
 rtl/mips_bus_lsu_lane_align.sv | 62 ++++++
 rtl/mips_bus_lsu.sv | 177 +++++++++++++++++
 tb/tb_mips_bus_lsu.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_bus load/store unit.
//   size_t      : access size (byte / half / word)
//   lsu_state_t : load/store FSM states
//   lsu_req_t   : fields of an accepted request needed after the bus phase
package mips_bus_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUS_RD  = 3'd1,
    BUS_WR  = 3'd2,
    RD_DATA = 3'd3,
    RESP    = 3'd4
  } lsu_state_t;

  typedef struct packed {
    size_t            size;
    logic             sext;
    logic [OFF_W-1:0] off;
  } lsu_req_t;

  // Raw 2-bit size code to size_t; the unused code 3 behaves as a word.
  function automatic size_t norm_size(input logic [1:0] s);
    case (s)
      2'd0:    norm_size = BYTE;
      2'd1:    norm_size = HALF;
      default: norm_size = WORD;
    endcase
  endfunction

endpackage

// File: rtl/mips_bus_lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   size, offset : access size and byte offset within the word
//   wdata        : right-aligned store data
//   sext         : sign-extend load result (byte/half)
//   readdata     : raw bus read word
//   be_c         : byte enables (lane i = byte offset i)
//   wdata_c      : store data replicated onto the addressed lanes
//   rdata_c      : extracted, right-aligned, extended load value
module lsu_lane_align
  import mips_bus_pkg::*;
(
  input  size_t             size,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sext,
  input  logic [DATA_W-1:0] readdata,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_c
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Byte enables and replicated store data.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (size)
      BYTE: begin
        be_c    = 4'(4'b0001 << offset);
        wdata_c = {4{wdata[7:0]}};
      end
      HALF: begin
        be_c    = offset[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Lane extraction and zero/sign extension of read data.
  always_comb begin
    rd_byte = readdata[7:0];
    case (offset)
      2'd0:    rd_byte = readdata[7:0];
      2'd1:    rd_byte = readdata[15:8];
      2'd2:    rd_byte = readdata[23:16];
      default: rd_byte = readdata[31:24];
    endcase
    rd_half = offset[1] ? readdata[31:16] : readdata[15:0];
    case (size)
      BYTE:    rdata_c = {{24{sext & rd_byte[7]}}, rd_byte};
      HALF:    rdata_c = {{16{sext & rd_half[15]}}, rd_half};
      default: rdata_c = readdata;
    endcase
  end

endmodule

// File: rtl/mips_bus_lsu.sv
// Load/store bus initiator: accepts one byte/half/word request, runs the
// matching read or write on the waitrequest bus and returns a one-cycle
// response with the aligned, extended load value.
//   clk, reset            : clock, async active-high reset
//   req_*                 : request from execute stage (req_ready high in IDLE)
//   rsp_valid/error/rdata : completion pulse, misalignment flag, load data
//   address/read/write/byteenable/writedata/waitrequest/readdata : bus pins
module mips_bus_lsu
  import mips_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_error,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [DATA_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] readdata
);

  lsu_state_t        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic              req_ready_d, read_d, write_d;
  logic              rsp_valid_d, rsp_error_d;
  logic [DATA_W-1:0] rsp_rdata_d, writedata_d;
  logic [ADDR_W-1:0] address_d;
  logic [BE_W-1:0]   byteenable_d;

  size_t             in_size;
  logic              misaligned;
  size_t             al_size;
  logic [OFF_W-1:0]  al_off;
  logic              al_sext;
  logic [BE_W-1:0]   al_be;
  logic [DATA_W-1:0] al_wdata, al_rdata;

  assign in_size = norm_size(req_size);

  // Alignment check on the incoming request.
  always_comb begin
    case (in_size)
      HALF:    misaligned = req_addr[0];
      WORD:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Lane logic sees the live request in IDLE, the latched one afterwards.
  assign al_size = (state_q == IDLE) ? in_size        : req_q.size;
  assign al_off  = (state_q == IDLE) ? req_addr[1:0]  : req_q.off;
  assign al_sext = (state_q == IDLE) ? req_signed     : req_q.sext;

  lsu_lane_align u_align (
    .size     (al_size),
    .offset   (al_off),
    .wdata    (req_wdata),
    .sext     (al_sext),
    .readdata (readdata),
    .be_c     (al_be),
    .wdata_c  (al_wdata),
    .rdata_c  (al_rdata)
  );

  // Next state and next registered output values.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    read_d       = 1'b0;
    write_d      = 1'b0;
    address_d    = address;
    byteenable_d = byteenable;
    writedata_d  = writedata;
    rsp_valid_d  = 1'b0;
    rsp_error_d  = rsp_error;
    rsp_rdata_d  = rsp_rdata;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d.size = in_size;
          req_d.sext = req_signed;
          req_d.off  = req_addr[1:0];
          if (misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            address_d    = {req_addr[ADDR_W-1:2], 2'b00};
            byteenable_d = al_be;
            writedata_d  = al_wdata;
            if (req_write) begin
              state_d = BUS_WR;
              write_d = 1'b1;
            end else begin
              state_d = BUS_RD;
              read_d  = 1'b1;
            end
          end
        end
      end
      BUS_WR: begin
        write_d = 1'b1;
        if (!waitrequest) begin
          state_d     = RESP;
          write_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      BUS_RD: begin
        read_d = 1'b1;
        if (!waitrequest) begin
          state_d = RD_DATA;
          read_d  = 1'b0;
        end
      end
      RD_DATA: begin
        // readdata is valid in this cycle; capture the aligned result.
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b0;
        rsp_rdata_d = al_rdata;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      req_ready  <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      req_ready  <= req_ready_d;
      read       <= read_d;
      write      <= write_d;
      address    <= address_d;
      byteenable <= byteenable_d;
      writedata  <= writedata_d;
      rsp_valid  <= rsp_valid_d;
      rsp_error  <= rsp_error_d;
      rsp_rdata  <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Directed, table-driven bench for mips_bus_lsu.
module tb_mips_bus_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] address;
  logic        read, write;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = 32'hDEADBEEF;

  always #5 clk = ~clk;

  mips_bus_lsu dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_error   (rsp_error),
    .rsp_rdata   (rsp_rdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          nwait;
    logic [3:0]  be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic        err;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int ready_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int nwait, input logic [3:0] be,
                              input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                              input logic err);
    vec_t v;
    v.wr = wr; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.nwait = nwait; v.be = be; v.exp_wd = exp_wd;
    v.exp_rd = exp_rd; v.err = err;
    return v;
  endfunction

  // Issue one request, play the bus responder, check strobes and response.
  task automatic run_txn(input vec_t v);
    int lat, strobes, exp_lat;
    bit got, rd_acc;
    ready_wait = 0;
    while (!req_ready && ready_wait < 20) begin
      step();
      ready_wait++;
    end
    chk("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sext;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    lat = 0; strobes = 0; got = 0; rd_acc = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      step();
      if (c == 1) begin
        req_valid = 1'b0;
        req_wdata = 32'h5A5A5A5A;
        req_addr  = 32'hFFFFFFFF;
      end
      readdata = rd_acc ? v.rdata : 32'hDEADBEEF;
      rd_acc = 0;
      if (read || write) begin
        strobes++;
        chk("strobe_dir", {30'd0, read, write}, v.wr ? 32'd1 : 32'd2);
        chk("address", address, {v.addr[31:2], 2'b00});
        chk("byteenable", 32'(byteenable), 32'(v.be));
        if (v.wr) chk("writedata", writedata, v.exp_wd);
        waitrequest = (strobes <= v.nwait);
        if (read && !waitrequest) rd_acc = 1;
      end else begin
        waitrequest = 1'b0;
      end
      if (rsp_valid) begin
        got = 1;
        lat = c;
      end
    end
    waitrequest = 1'b0;
    exp_lat = v.err ? 1 : (v.wr ? 2 + v.nwait : 3 + v.nwait);
    if (!got) $display("FAIL rsp_timeout: got none expected rsp_valid at %0d", exp_lat);
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("strobe_cycles", 32'(strobes), v.err ? 32'd0 : 32'(v.nwait + 1));
    chk("rsp_error", 32'(rsp_error), 32'(v.err));
    chk("rsp_rdata", rsp_rdata, v.exp_rd);
    // One cycle later: pulse gone, result held, ready again.
    step();
    chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    chk("rsp_rdata_hold", rsp_rdata, v.exp_rd);
    chk("rsp_error_hold", 32'(rsp_error), 32'(v.err));
    chk("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  vec_t        vecs[$];
  logic [3:0]  b2b_be[4];
  logic [31:0] b2b_wd[4];
  int          pulses;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //   wr size sx addr           wdata          rdata          nw be       exp_wd         exp_rd         err
    vecs.push_back(mk(0, 2, 0, 32'hBFC0002C, 32'h0,        32'hFFFFFFFF, 0, 4'b1111, 32'h0,        32'hFFFFFFFF, 0));
    vecs.push_back(mk(0, 0, 1, 32'hBFC00023, 32'h0,        32'h80123456, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 0, 0, 32'hBFC00023, 32'h0,        32'h80123456, 0, 4'b1000, 32'h0,        32'h00000080, 0));
    vecs.push_back(mk(1, 1, 0, 32'hBFC00032, 32'h00001234, 32'h0,        3, 4'b1100, 32'h12341234, 32'h00000000, 0));
    vecs.push_back(mk(0, 2, 0, 32'hBFC00031, 32'h0,        32'h12345678, 0, 4'b0000, 32'h0,        32'h00000000, 1));
    vecs.push_back(mk(0, 1, 1, 32'h00001002, 32'h0,        32'h80017FFF, 0, 4'b1100, 32'h0,        32'hFFFF8001, 0));
    vecs.push_back(mk(0, 1, 0, 32'h00001000, 32'h0,        32'h8001F00D, 0, 4'b0011, 32'h0,        32'h0000F00D, 0));
    vecs.push_back(mk(0, 1, 1, 32'h00001000, 32'h0,        32'h1234F00D, 1, 4'b0011, 32'h0,        32'hFFFFF00D, 0));
    vecs.push_back(mk(0, 0, 1, 32'h00002001, 32'h0,        32'h00007F00, 0, 4'b0010, 32'h0,        32'h0000007F, 0));
    vecs.push_back(mk(1, 2, 0, 32'h00003000, 32'hCAFEBABE, 32'h0,        1, 4'b1111, 32'hCAFEBABE, 32'h00000000, 0));
    vecs.push_back(mk(1, 0, 0, 32'h00004002, 32'hFFFFFFA5, 32'h0,        0, 4'b0100, 32'hA5A5A5A5, 32'h00000000, 0));
    vecs.push_back(mk(1, 1, 0, 32'h00005001, 32'h0000BEEF, 32'h0,        0, 4'b0000, 32'h0,        32'h00000000, 1));
    vecs.push_back(mk(0, 3, 1, 32'h00006000, 32'h0,        32'h11223344, 0, 4'b1111, 32'h0,        32'h11223344, 0));
    vecs.push_back(mk(0, 3, 0, 32'h00006002, 32'h0,        32'h11223344, 0, 4'b0000, 32'h0,        32'h00000000, 1));
    vecs.push_back(mk(0, 2, 0, 32'h00007004, 32'h0,        32'h0BADF00D, 2, 4'b1111, 32'h0,        32'h0BADF00D, 0));
    vecs.push_back(mk(1, 1, 0, 32'h00008000, 32'hFFFF8765, 32'h0,        0, 4'b0011, 32'h87658765, 32'h00000000, 0));

    // Reset state.
    #3 reset = 1'b1;
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_byteenable", 32'(byteenable), 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    step();
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Back-to-back byte stores to offsets 0..3.
    b2b_be[0] = 4'b0001; b2b_be[1] = 4'b0010; b2b_be[2] = 4'b0100; b2b_be[3] = 4'b1000;
    b2b_wd[0] = 32'hC0C0C0C0; b2b_wd[1] = 32'hC1C1C1C1;
    b2b_wd[2] = 32'hC2C2C2C2; b2b_wd[3] = 32'hC3C3C3C3;
    for (int o = 0; o < 4; o++) begin
      run_txn(mk(1, 0, 0, 32'h00009000 + 32'(o), 32'h000000C0 + 32'(o), 32'h0, 0,
                 b2b_be[o], b2b_wd[o], 32'h0, 0));
      chk("b2b_accept_wait", 32'(ready_wait), 32'd0);
    end

    // Reset during BUS_RD with the responder stalling.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0000A000;
    step();
    req_valid = 1'b0;
    waitrequest = 1'b1;
    chk("mid_rst_read_before", 32'(read), 32'd1);
    step();
    chk("mid_rst_read_stalled", 32'(read), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_read_async", 32'(read), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    reset = 1'b0;
    waitrequest = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rsp_valid) pulses++;
    end
    chk("mid_rst_no_rsp", 32'(pulses), 32'd0);
    chk("mid_rst_read_after", 32'(read), 32'd0);
    chk("mid_rst_ready_after", 32'(req_ready), 32'd1);

    // A normal load still works after the abandoned one.
    run_txn(mk(0, 0, 1, 32'h0000B002, 32'h0, 32'h00FE0000, 0, 4'b0100, 32'h0, 32'hFFFFFFFE, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
